// File: rtl/div_share_sched.sv
// Round-robin shared divide-by-constant unit: reciprocal multiply with round-half-up.
// Latency 2 cycles grant-to-result; stalls the whole pipeline and grants nothing while a result waits.
module div_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH = 8,
  parameter int COEF_WIDTH = 18,
  parameter logic [COEF_WIDTH-1:0] DEFAULT_COEF = 6096,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req_v,
  input  logic [NUM_REQ*DWIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_cfg_we,
  input  logic [IDW-1:0]            i_cfg_sel,
  input  logic [COEF_WIDTH-1:0]     i_cfg_coef,
  output logic                      o_res_v,
  output logic [DWIDTH-1:0]         o_res_data,
  output logic [IDW-1:0]            o_res_id,
  input  logic                      i_res_ready,
  output logic                      o_busy
);

  localparam int PW = DWIDTH + COEF_WIDTH;
  localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [COEF_WIDTH-1:0] coef_q [NUM_REQ];
  logic [COEF_WIDTH-1:0] coef_d [NUM_REQ];
  logic [PW-1:0]         p1_q, p1_d;
  logic [IDW-1:0]        id1_q, id1_d;
  logic                  v1_q, v1_d;
  logic                  res_v_q, res_v_d;
  logic [DWIDTH-1:0]     res_data_q, res_data_d;
  logic [IDW-1:0]        res_id_q, res_id_d;

  logic                  adv;
  logic                  gnt_vld;
  logic [IDW-1:0]        gnt_idx;
  logic [IDW-1:0]        cand;
  logic [DWIDTH-1:0]     gnt_dat;
  logic [COEF_WIDTH-1:0] gnt_coef;

  assign adv = !res_v_q || i_res_ready;

  // Search starts one past the last winner; grants are suppressed while in reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NUM_REQ);
      if (adv && !rst && !gnt_vld && i_req_v[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_dat     = i_req_data[gnt_idx*DWIDTH +: DWIDTH];
  assign gnt_coef    = coef_q[gnt_idx];
  assign o_req_ready = gnt_vld ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  // A write landing with a grant to the same entry is seen only by later grants.
  always_comb begin
    coef_d = coef_q;
    if (i_cfg_we && int'(i_cfg_sel) < NUM_REQ) begin
      coef_d[i_cfg_sel] = i_cfg_coef;
    end
  end

  always_comb begin
    ptr_d      = gnt_vld ? gnt_idx : ptr_q;
    v1_d       = v1_q;
    p1_d       = p1_q;
    id1_d      = id1_q;
    res_v_d    = res_v_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    if (adv) begin
      v1_d = gnt_vld;
      if (gnt_vld) begin
        p1_d  = PW'(gnt_dat) * PW'(gnt_coef);
        id1_d = gnt_idx;
      end
      // coef < 2^COEF_WIDTH keeps the rounded quotient <= dividend, so no overflow.
      res_v_d    = v1_q;
      res_data_d = p1_q[PW-1:COEF_WIDTH] + DWIDTH'(p1_q[COEF_WIDTH-1]);
      res_id_d   = id1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= PTR_RST;
      p1_q       <= '0;
      id1_q      <= '0;
      v1_q       <= 1'b0;
      res_v_q    <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        coef_q[k] <= DEFAULT_COEF;
      end
    end else begin
      ptr_q      <= ptr_d;
      p1_q       <= p1_d;
      id1_q      <= id1_d;
      v1_q       <= v1_d;
      res_v_q    <= res_v_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      for (int k = 0; k < NUM_REQ; k++) begin
        coef_q[k] <= coef_d[k];
      end
    end
  end

  assign o_res_v    = res_v_q;
  assign o_res_data = res_data_q;
  assign o_res_id   = res_id_q;
  assign o_busy     = v1_q || res_v_q;

endmodule

// File: tb/tb_div_share_sched.sv
// Scoreboard bench for div_share_sched: a reference arbiter/coef table predicts grants and quotients.
module tb_div_share_sched;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int CW = 18;
  localparam logic [CW-1:0] DEF_COEF = 18'd6096;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    i_req_v = '0;
  logic [NR*DW-1:0] i_req_data = '0;
  logic [NR-1:0]    o_req_ready;
  logic             i_cfg_we = 1'b0;
  logic [1:0]       i_cfg_sel = '0;
  logic [CW-1:0]    i_cfg_coef = '0;
  logic             o_res_v;
  logic [DW-1:0]    o_res_data;
  logic [1:0]       o_res_id;
  logic             i_res_ready = 1'b1;
  logic             o_busy;

  div_share_sched dut (
    .clk(clk), .rst(rst),
    .i_req_v(i_req_v), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel), .i_cfg_coef(i_cfg_coef),
    .o_res_v(o_res_v), .o_res_data(o_res_data), .o_res_id(o_res_id),
    .i_res_ready(i_res_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] q;
    int         g;
  } ent_t;

  ent_t          sb[$];
  logic [7:0]    src[NR][$];
  logic [CW-1:0] mcoef[NR];
  int            mptr;
  int            last_del;
  int            cyc = 0;
  logic [NR-1:0] hs = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_q(input logic [7:0] x, input logic [CW-1:0] c);
    longint p;
    p = longint'(x) * longint'(c);
    return 8'((p + (longint'(1) << (CW - 1))) >> CW);
  endfunction

  task automatic drive_reqs();
    for (int k = 0; k < NR; k++) begin
      i_req_v[k] = (src[k].size() != 0);
      i_req_data[k*DW +: DW] = (src[k].size() != 0) ? src[k][0] : 8'd0;
    end
  endtask

  always @(posedge clk) cyc++;

  // Producers retire a sample one step after its handshake.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NR; k++) begin
      if (hs[k] && src[k].size() != 0) void'(src[k].pop_front());
    end
    hs = '0;
    drive_reqs();
  end

  always @(negedge clk) begin
    logic          exp_v;
    logic          adv_m;
    logic          found;
    int            gk;
    logic [NR-1:0] exp_gnt;
    ent_t          e;
    if (rst) begin
      sb.delete();
      mptr = NR - 1;
      last_del = -10;
      hs = '0;
      for (int k = 0; k < NR; k++) mcoef[k] = DEF_COEF;
    end else begin
      exp_v = (sb.size() != 0) &&
              (cyc >= ((sb[0].g + 2 > last_del + 1) ? sb[0].g + 2 : last_del + 1));
      check_eq("res_v", 32'(o_res_v), 32'(exp_v));
      check_eq("busy", 32'(o_busy), 32'(sb.size() != 0));
      adv_m = !exp_v || i_res_ready;
      found = 1'b0;
      gk = 0;
      if (adv_m) begin
        for (int i = 1; i <= NR; i++) begin
          if (!found && i_req_v[(mptr + i) % NR]) begin
            found = 1'b1;
            gk = (mptr + i) % NR;
          end
        end
      end
      exp_gnt = found ? (NR'(1) << gk) : '0;
      check_eq("req_ready", 32'(o_req_ready), 32'(exp_gnt));
      hs = i_req_v & o_req_ready;
      if (exp_v && i_res_ready) begin
        e = sb.pop_front();
        check_eq("res_data", 32'(o_res_data), 32'(e.q));
        check_eq("res_id", 32'(o_res_id), 32'(e.id));
        last_del = cyc;
      end
      if (found) begin
        e.id = 2'(gk);
        e.q  = model_q(i_req_data[gk*DW +: DW], mcoef[gk]);
        e.g  = cyc;
        sb.push_back(e);
        mptr = gk;
      end
      if (i_cfg_we && int'(i_cfg_sel) < NR) mcoef[i_cfg_sel] = i_cfg_coef;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((src[0].size() + src[1].size() + src[2].size() + src[3].size() + sb.size() != 0 || o_busy)
           && n < budget) begin
      step();
      n++;
    end
    check_eq("idle_timeout", 32'(n >= budget), 32'd0);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [CW-1:0] c);
    i_cfg_we = 1'b1;
    i_cfg_sel = sel;
    i_cfg_coef = c;
    step();
    i_cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    #7;
    check_eq("rst_res_v", 32'(o_res_v), 32'd0);
    check_eq("rst_res_data", 32'(o_res_data), 32'd0);
    check_eq("rst_res_id", 32'(o_res_id), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_req_ready", 32'(o_req_ready), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Default coefficient, single requester.
    src[2].push_back(8'd200); src[2].push_back(8'd43); src[2].push_back(8'd0);
    drive_reqs();
    wait_idle(50);

    // Divide-by-3 coefficient on requester 1 mixed with default on requester 0.
    cfg_write(2'd1, 18'd87381);
    src[1].push_back(8'd255); src[0].push_back(8'd255);
    drive_reqs();
    wait_idle(50);

    // All requesters contend continuously.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++) src[k].push_back(8'(17 + 40 * k + r * 9));
    drive_reqs();
    wait_idle(50);

    // Output backpressure on a stream from requester 3.
    src[3].push_back(8'd10); src[3].push_back(8'd20); src[3].push_back(8'd30);
    drive_reqs();
    n = 0;
    while (!o_res_v && n < 20) begin step(); n++; end
    check_eq("first_res_timeout", 32'(n >= 20), 32'd0);
    i_res_ready = 1'b0;
    src[0].push_back(8'd7); src[0].push_back(8'd8);
    drive_reqs();
    for (int s = 0; s < 3; s++) begin
      #1;
      check_eq("stall_hold", 32'(o_res_data), 32'd0);
      check_eq("stall_ready", 32'(o_req_ready), 32'd0);
      step();
    end
    i_res_ready = 1'b1;
    wait_idle(50);

    // Asynchronous reset with two results in flight.
    src[1].push_back(8'd100); src[1].push_back(8'd101);
    drive_reqs();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int k = 0; k < NR; k++) src[k].delete();
    drive_reqs();
    #1;
    check_eq("arst_res_v", 32'(o_res_v), 32'd0);
    check_eq("arst_busy", 32'(o_busy), 32'd0);
    check_eq("arst_res_data", 32'(o_res_data), 32'd0);
    check_eq("arst_req_ready", 32'(o_req_ready), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    src[3].push_back(8'd200); src[1].push_back(8'd255); src[0].push_back(8'd43);
    drive_reqs();
    wait_idle(50);

    // Coefficient write coinciding with a grant, then a zero coefficient.
    src[0].push_back(8'd255); src[0].push_back(8'd255);
    i_cfg_we = 1'b1;
    i_cfg_sel = 2'd0;
    i_cfg_coef = 18'd87381;
    drive_reqs();
    step();
    i_cfg_we = 1'b0;
    wait_idle(50);
    cfg_write(2'd2, 18'd0);
    src[2].push_back(8'd255);
    drive_reqs();
    wait_idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
